fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data word width.
REQ-002 The block SHALL have parameter BURST, default 4, giving the maximum words per grant (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 req  input  3  per-requester write request; bit i is held high with din<i> stable until the word is acked.
REQ-006 din0, din1, din2  input  WIDTH each  per-requester write data.
REQ-007 fullp  input  1  full flag from the downstream synchronous FIFO.
REQ-008 writep  output  1  write strobe to the FIFO.
REQ-009 fifo_din  output  WIDTH  write data to the FIFO.
REQ-010 gnt  output  3  registered one-hot grant, or 0 when idle.
REQ-011 ack  output  3  one-hot; ack[i] high means din<i> is written at this posedge.

Function
REQ-012 The block SHALL be a two-state machine with states IDLE and GRANT, plus these registers:
- owner, 2 bits
- last, 2 bits
- bcnt, 4 bits
REQ-013 In IDLE with req != 0, the block SHALL select the first requester with req high in round-robin order last+1, last+2, last+3 (mod 3), then in the next cycle enter GRANT with gnt = onehot(owner), bcnt = 0 and last = owner.
REQ-014 In IDLE with req == 0, the block SHALL remain in IDLE with gnt = 0.
REQ-015 In GRANT, the write strobe SHALL be combinational: writep = req[owner] and not fullp.
REQ-016 fifo_din SHALL equal din<owner> in GRANT and SHALL be 0 in IDLE.
REQ-017 ack SHALL equal onehot(owner) gated by writep, and SHALL be 0 otherwise.
REQ-018 Each cycle with writep high SHALL increment bcnt by 1.
REQ-019 The grant SHALL end at the posedge where either of these holds:
- writep is high and bcnt == BURST-1;
- req[owner] is low.
REQ-020 At the end of a grant with req != 0, the block SHALL re-arbitrate in the same cycle in order owner+1, owner+2, owner+3 (mod 3), so the current owner is lowest priority. It SHALL load the new gnt with no idle bubble, reset bcnt to 0 and update last.
REQ-021 At the end of a grant with req == 0, the block SHALL enter IDLE.
REQ-022 While fullp is high in GRANT:
- writep and ack SHALL be 0;
- bcnt SHALL hold;
- the grant SHALL be held indefinitely, with no timeout, unless req[owner] drops.
REQ-023 A requester that is the sole requester at the end of a grant SHALL be re-granted immediately with bcnt = 0.
REQ-024 Any change on a non-owner req bit SHALL have no effect on outputs until re-arbitration.
REQ-025 writep SHALL never be high while fullp is high, and at most one ack bit SHALL be high in any cycle.
REQ-026 Worst-case latency from a requester's req rising to its first ack SHALL be 1 + 2*BURST cycles when fullp is low.

Reset
REQ-027 When rstn is low, the block SHALL asynchronously set:
- state = IDLE;
- gnt = 0, owner = 0, bcnt = 0;
- last = 2, so requester 0 has top priority after reset.
REQ-028 While rstn is low, writep, ack and fifo_din SHALL be 0.
REQ-029 Reset asserted mid-grant SHALL abandon the burst; the word on that cycle SHALL NOT be acked.
REQ-030 After rstn deasserts, the first grant SHALL occur no earlier than the second posedge.

Verification
REQ-031 Single requester: req=3'b001 held with data 0x0001..0x0006, fullp=0 -> gnt=001 one cycle after req, then:
- acks for words 1-4;
- re-grant with no gap;
- acks for words 5-6;
- FIFO receives 0x0001..0x0006 in order.
REQ-032 Round-robin fairness: req=3'b111 held continuously, BURST=4 -> grant order 0,1,2,0,… with exactly 4 acks per grant and no idle cycles between grants.
REQ-033 Backpressure: owner 1 mid-burst with bcnt=2, fullp=1 for 5 cycles -> writep=0 and gnt=010 held for those 5 cycles; the burst resumes with 2 more acks after fullp falls.
REQ-034 Early release: owner 2 drops req after 1 ack while req[0]=1 -> gnt switches to 001 at the next posedge, and requester 0 starts a fresh 4-word burst.
REQ-035 Reset mid-burst: rstn low asynchronously while gnt=100 -> gnt=0 and writep=0 immediately; after release with req=3'b110, requester 1 is granted first.
REQ-036 Bench checker: every fifo_din accepted SHALL match the scoreboard for the acked requester, with no lost or duplicated words over 500 random req/fullp cycles.

Source files
------------

// File: rtl/fifo_wr_arb_if.sv
// Write-side bundle between three requesters, the arbiter and a downstream FIFO.
// master = requester/FIFO side that drives req, data and fullp; slave = the arbiter.
interface fifo_wr_arb_if #(
  parameter int WIDTH = 16
);
  logic [2:0]       req;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic             fullp;
  logic             writep;
  logic [WIDTH-1:0] fifo_din;
  logic [2:0]       gnt;
  logic [2:0]       ack;

  modport master (
    output req, din0, din1, din2, fullp,
    input  writep, fifo_din, gnt, ack
  );

  modport slave (
    input  req, din0, din1, din2, fullp,
    output writep, fifo_din, gnt, ack
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: three requesters share one FIFO write port,
// each grant lasting up to BURST words; the current owner is lowest priority on re-arbitration.
module fifo_wr_arb #(
  parameter int WIDTH = 16,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rstn,
  fifo_wr_arb_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [1:0]  owner_r, owner_nxt_s;
  logic [1:0]  last_r, last_nxt_s;
  logic [3:0]  bcnt_r, bcnt_nxt_s;
  logic [2:0]  gnt_r, gnt_nxt_s;
  logic        armed_r;
  logic        req_own_s;
  logic        writep_s;
  logic        end_s;
  logic        any_req_s;
  logic [1:0]  rr_base_s;
  logic [1:0]  pick_s;
  logic [WIDTH-1:0] fifo_din_s;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // Scan base+3 down to base+1 so the earliest requester in rotation order wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [2:0] r);
    logic [2:0] sum;
    logic [1:0] idx;
    rr_pick = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      sum = {1'b0, base} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (r[idx]) begin
        rr_pick = idx;
      end
    end
  endfunction

  assign any_req_s = (bus.req != 3'b000);
  assign req_own_s = ((bus.req & onehot(owner_r)) != 3'b000);
  assign writep_s  = (state_r == GRANT) && req_own_s && !bus.fullp;
  assign end_s     = !req_own_s || (writep_s && (bcnt_r == 4'(BURST - 1)));
  assign rr_base_s = (state_r == GRANT) ? owner_r : last_r;
  assign pick_s    = rr_pick(rr_base_s, bus.req);

  // Next-state: arbitrate from IDLE, or at grant end re-arbitrate without a bubble.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    last_nxt_s  = last_r;
    bcnt_nxt_s  = bcnt_r;
    gnt_nxt_s   = gnt_r;
    case (state_r)
      IDLE: begin
        if (armed_r && any_req_s) begin
          state_nxt_s = GRANT;
          owner_nxt_s = pick_s;
          last_nxt_s  = pick_s;
          gnt_nxt_s   = onehot(pick_s);
          bcnt_nxt_s  = 4'd0;
        end else begin
          gnt_nxt_s   = 3'b000;
        end
      end
      GRANT: begin
        if (end_s && any_req_s) begin
          owner_nxt_s = pick_s;
          last_nxt_s  = pick_s;
          gnt_nxt_s   = onehot(pick_s);
          bcnt_nxt_s  = 4'd0;
        end else if (end_s) begin
          state_nxt_s = IDLE;
          gnt_nxt_s   = 3'b000;
          bcnt_nxt_s  = 4'd0;
        end else if (writep_s) begin
          bcnt_nxt_s  = bcnt_r + 4'd1;
        end else begin
          bcnt_nxt_s  = bcnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = 3'b000;
        bcnt_nxt_s  = 4'd0;
      end
    endcase
  end

  // State registers; armed_r holds off arbitration until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      owner_r <= 2'd0;
      last_r  <= 2'd2;
      bcnt_r  <= 4'd0;
      gnt_r   <= 3'b000;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      last_r  <= last_nxt_s;
      bcnt_r  <= bcnt_nxt_s;
      gnt_r   <= gnt_nxt_s;
      armed_r <= 1'b1;
    end
  end

  // Data path mux: owner's word during a grant, zero otherwise.
  always_comb begin
    fifo_din_s = {WIDTH{1'b0}};
    if (state_r == GRANT) begin
      case (owner_r)
        2'd0:    fifo_din_s = bus.din0;
        2'd1:    fifo_din_s = bus.din1;
        2'd2:    fifo_din_s = bus.din2;
        default: fifo_din_s = {WIDTH{1'b0}};
      endcase
    end else begin
      fifo_din_s = {WIDTH{1'b0}};
    end
  end

  assign bus.writep   = writep_s;
  assign bus.ack      = onehot(owner_r) & {3{writep_s}};
  assign bus.gnt      = gnt_r;
  assign bus.fifo_din = fifo_din_s;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized bench for fifo_wr_arb: per-requester word scoreboards plus a
// rule-level arbitration model checked every cycle on the falling edge.
module tb_fifo_wr_arb;
  localparam int WIDTH = 16;
  localparam int BURST = 4;

  logic clk;
  logic rstn;

  fifo_wr_arb_if #(.WIDTH(WIDTH)) bus ();

  fifo_wr_arb #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  logic [15:0] exp_q [3][$];
  logic [15:0] log_q [$];
  logic [15:0] next_val [3];
  int remaining [3];
  int acked [3];

  // reference model state
  int m_owner;
  int m_last;
  int m_cnt;
  bit m_armed;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr(input int base, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      if (r[(base + k) % 3]) return (base + k) % 3;
    end
    return -1;
  endfunction

  // monitor: compare DUT against the model and pop scoreboard on every write
  always @(negedge clk) begin
    int exp_gnt;
    int exp_wr;
    logic [15:0] w;
    if (!rstn) begin
      m_owner = -1;
      m_last  = 2;
      m_cnt   = 0;
      m_armed = 1'b0;
      check("reset_outputs", int'({bus.gnt, bus.ack, bus.writep, bus.fifo_din}), 0);
    end else begin
      exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
      exp_wr  = (m_owner >= 0 && bus.req[m_owner] && !bus.fullp) ? 1 : 0;
      check("gnt", int'(bus.gnt), exp_gnt);
      check("writep", int'(bus.writep), exp_wr);
      check("ack", int'(bus.ack), exp_wr ? exp_gnt : 0);
      if (exp_wr != 0) begin
        if (exp_q[m_owner].size() == 0) begin
          check("word_available", 0, 1);
        end else begin
          w = exp_q[m_owner].pop_front();
          check("fifo_din", int'(bus.fifo_din), int'(w));
          log_q.push_back(bus.fifo_din);
        end
      end
      if (m_owner < 0) begin
        if (!m_armed) begin
          m_armed = 1'b1;
        end else if (bus.req != 3'b000) begin
          m_owner = rr(m_last, bus.req);
          m_last  = m_owner;
          m_cnt   = 0;
        end
      end else begin
        if (exp_wr != 0) m_cnt++;
        if (!bus.req[m_owner] || m_cnt == BURST) begin
          if (bus.req != 3'b000) begin
            m_owner = rr(m_owner, bus.req);
            m_last  = m_owner;
            m_cnt   = 0;
          end else begin
            m_owner = -1;
          end
        end
      end
    end
  end

  task automatic present(input int i);
    logic [15:0] v;
    v = next_val[i];
    next_val[i] = next_val[i] + 16'd1;
    case (i)
      0: bus.din0 = v;
      1: bus.din1 = v;
      default: bus.din2 = v;
    endcase
    bus.req[i] = 1'b1;
    exp_q[i].push_back(v);
  endtask

  task automatic start(input int i, input int n);
    if (remaining[i] == 0 && n > 0) begin
      remaining[i] = n;
      present(i);
    end
  endtask

  task automatic step(input logic fp);
    logic [2:0] a;
    @(negedge clk);
    a = bus.ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (a[i] && remaining[i] > 0) begin
        acked[i]++;
        remaining[i]--;
        if (remaining[i] > 0) present(i);
        else bus.req[i] = 1'b0;
      end
    end
    bus.fullp = fp;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((remaining[0] + remaining[1] + remaining[2]) != 0 && n < 400) begin
      step(1'b0);
      n++;
    end
    check("drain_timeout", (remaining[0] + remaining[1] + remaining[2]), 0);
    step(1'b0);
    step(1'b0);
  endtask

  initial begin
    int n;
    int base;
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    bus.req = 3'b000;
    bus.din0 = 16'h0000;
    bus.din1 = 16'h0000;
    bus.din2 = 16'h0000;
    bus.fullp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_val[i] = 16'((i << 12) + 1);
      remaining[i] = 0;
      acked[i] = 0;
    end
    repeat (3) step(1'b0);
    rstn = 1'b1;
    step(1'b0);
    step(1'b0);

    // single requester, six words through two back-to-back grants
    log_q.delete();
    start(0, 6);
    wait_idle();
    check("single_count", log_q.size(), 6);
    for (int k = 0; k < 6 && k < log_q.size(); k++) check("single_word", int'(log_q[k]), k + 1);

    // all three requesting continuously
    start(0, 12);
    start(1, 12);
    start(2, 12);
    wait_idle();

    // backpressure in the middle of requester 1's burst
    base = acked[1];
    start(1, 4);
    n = 0;
    while (acked[1] < base + 2 && n < 50) begin
      step(1'b0);
      n++;
    end
    check("bp_reach_mid", acked[1] - base, 2);
    bus.fullp = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b1);
      check("bp_gnt_hold", int'(bus.gnt), 3'b010);
      check("bp_no_write", int'(bus.writep), 0);
    end
    bus.fullp = 1'b0;
    wait_idle();
    check("bp_total_acks", acked[1] - base, 4);

    // early release by requester 2 while requester 0 waits
    start(2, 1);
    step(1'b0);
    start(0, 4);
    wait_idle();

    // asynchronous reset in the middle of requester 2's grant
    start(0, 8);
    start(1, 8);
    start(2, 8);
    n = 0;
    while (bus.gnt != 3'b100 && n < 60) begin
      step(1'b0);
      n++;
    end
    check("reach_gnt2", int'(bus.gnt), 3'b100);
    #1;
    rstn = 1'b0;
    #1;
    check("async_rst_gnt", int'(bus.gnt), 0);
    check("async_rst_writep", int'(bus.writep), 0);
    for (int i = 0; i < 3; i++) begin
      bus.req[i] = 1'b0;
      remaining[i] = 0;
      exp_q[i].delete();
    end
    step(1'b0);
    start(1, 3);
    start(2, 3);
    step(1'b0);
    rstn = 1'b1;
    n = 0;
    while (bus.gnt == 3'b000 && n < 10) begin
      step(1'b0);
      n++;
    end
    check("post_rst_first", int'(bus.gnt), 3'b010);
    wait_idle();

    // randomized traffic with random FIFO-full
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (remaining[i] == 0 && $urandom_range(0, 3) == 0) start(i, $urandom_range(1, 6));
      end
      step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end
    bus.fullp = 1'b0;
    wait_idle();

    for (int i = 0; i < 3; i++) check("leftover_words", exp_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
